result_unload: RTL and testbench

Read-out side of the matrix unit's APB data path. It captures one 144-bit result (nine 16-bit elements) from the compute core and presents it on `PRDATA` as five sequential 32-bit words, one word per APB read of the result address. Word order is most-significant first, with the short last word right-aligned. This mirrors how operand buffers assemble wide registers from successive `PWDATA` writes.

---
 rtl/result_unload.sv | 122 ++++++++++++
 tb/tb_result_unload.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/result_unload.sv
// result_unload
//   Captures one 144-bit result (nine 16-bit elements) from the compute core
//   and returns it over the APB read path as five 32-bit words. The first word
//   returned is the most significant. The last word holds only the final
//   element, right-aligned and zero-padded.
//
// Ports
//   clk           system clock, rising-edge active
//   rst           synchronous reset, active-low
//   result_valid  one-cycle capture strobe from the core
//   result_data   144-bit result, element 0 in [143:128]
//   read_en       APB read strobe for the result address (one word per strobe)
//   PRDATA        current word, combinational from held state
//   result_ready  registered: a captured result still has unread words
//   unload_done   combinational: this cycle's read is the fifth and final one
//   overrun       registered sticky: a result arrived while one was still unread
//   underrun      registered sticky: a read arrived with nothing held
module result_unload (
    input  logic         clk,
    input  logic         rst,
    input  logic         result_valid,
    input  logic [143:0] result_data,
    input  logic         read_en,
    output logic [31:0]  PRDATA,
    output logic         result_ready,
    output logic         unload_done,
    output logic         overrun,
    output logic         underrun
);

    typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

    state_t       state_q;
    state_t       state_d;
    logic [143:0] sreg;
    logic [2:0]   cnt;
    logic         final_read;

    // The fifth read is the only point at which a new result can be accepted
    // while one is still held.
    assign final_read = (state_q == HOLD) && read_en && (cnt == 3'd4);

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (state_q == IDLE) begin
            if (result_valid) begin
                state_d = HOLD;
            end
        end else begin
            if (final_read && !result_valid) begin
                state_d = IDLE;
            end
        end
    end

    // Output logic
    always_comb begin
        PRDATA      = 32'h0;
        unload_done = 1'b0;
        if (state_q == HOLD) begin
            if (cnt == 3'd4) begin
                PRDATA = {16'h0000, sreg[143:128]};
            end else begin
                PRDATA = sreg[143:112];
            end
            unload_done = final_read;
        end
    end

    // Data shift register, word counter and status flags
    always_ff @(posedge clk) begin
        if (!rst) begin
            sreg         <= '0;
            cnt          <= 3'd0;
            result_ready <= 1'b0;
            overrun      <= 1'b0;
            underrun     <= 1'b0;
        end else begin
            result_ready <= (state_d == HOLD);
            if (state_q == IDLE) begin
                if (result_valid) begin
                    sreg <= result_data;
                    cnt  <= 3'd0;
                end else if (read_en) begin
                    underrun <= 1'b1;
                end
            end else begin
                if (final_read) begin
                    // Back-to-back results: the new one is taken as the old
                    // one finishes, so no overrun is flagged.
                    if (result_valid) begin
                        sreg <= result_data;
                    end else begin
                        sreg <= '0;
                    end
                    cnt <= 3'd0;
                end else begin
                    if (read_en) begin
                        sreg <= {sreg[111:0], 32'h0};
                        cnt  <= cnt + 3'd1;
                    end
                    // A result arriving mid-unload is dropped; the current
                    // unload continues untouched.
                    if (result_valid) begin
                        overrun <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_result_unload.sv
// tb_result_unload
//   Scoreboard bench for result_unload. Each accepted capture pushes its five
//   expected words into a queue. Each read pops one word and compares it with
//   PRDATA. A small model tracks the remaining word count and the sticky flags.
module tb_result_unload;

    logic         clk;
    logic         rst;
    logic         result_valid;
    logic [143:0] result_data;
    logic         read_en;
    logic [31:0]  PRDATA;
    logic         result_ready;
    logic         unload_done;
    logic         overrun;
    logic         underrun;

    result_unload dut (
        .clk          (clk),
        .rst          (rst),
        .result_valid (result_valid),
        .result_data  (result_data),
        .read_en      (read_en),
        .PRDATA       (PRDATA),
        .result_ready (result_ready),
        .unload_done  (unload_done),
        .overrun      (overrun),
        .underrun     (underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_q[$];
    int          rem     = 0;
    logic        exp_ovr = 1'b0;
    logic        exp_unr = 1'b0;

    localparam logic [143:0] DATA_A = 144'h0123456789ABCDEF112233445566778899AA;
    localparam logic [143:0] DATA_B = 144'hFEDCBA9876543210A5A5C3C30F0FF0F01234;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%08h exp=%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] word_of(input logic [143:0] d, input int i);
        logic [31:0] w;
        if (i < 4) w = d[143 - 32*i -: 32];
        else       w = {16'h0000, d[15:0]};
        return w;
    endfunction

    // One clock cycle. Inputs are driven just after an edge. Combinational
    // outputs are checked before the next edge. Registered outputs are
    // checked just after that edge.
    task automatic step(input logic rv, input logic [143:0] d, input logic re);
        int rem_before;
        result_valid = rv;
        result_data  = d;
        read_en      = re;
        #4;
        rem_before = rem;
        if (re && rem > 0) begin
            chk("prdata_read", PRDATA, exp_q.pop_front());
            chk("unload_done", {31'd0, unload_done}, {31'd0, rem == 1});
            rem--;
        end else begin
            if (rem > 0) chk("prdata_hold", PRDATA, exp_q[0]);
            else         chk("prdata_idle", PRDATA, 32'h0);
            chk("unload_done_low", {31'd0, unload_done}, 32'd0);
        end
        if (re && rem_before == 0 && !rv) exp_unr = 1'b1;
        if (rv) begin
            if (rem_before == 0 || (re && rem_before == 1)) begin
                for (int i = 0; i < 5; i++) exp_q.push_back(word_of(d, i));
                rem = 5;
            end else begin
                exp_ovr = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        result_valid = 1'b0;
        read_en      = 1'b0;
        chk("result_ready", {31'd0, result_ready}, {31'd0, rem > 0});
        chk("overrun", {31'd0, overrun}, {31'd0, exp_ovr});
        chk("underrun", {31'd0, underrun}, {31'd0, exp_unr});
    endtask

    task automatic do_reset();
        rst          = 1'b0;
        result_valid = 1'b0;
        read_en      = 1'b0;
        #4;
        chk("done_in_reset", {31'd0, unload_done}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        rem     = 0;
        exp_ovr = 1'b0;
        exp_unr = 1'b0;
        chk("rst_prdata", PRDATA, 32'h0);
        chk("rst_ready", {31'd0, result_ready}, 32'd0);
        chk("rst_done", {31'd0, unload_done}, 32'd0);
        chk("rst_overrun", {31'd0, overrun}, 32'd0);
        chk("rst_underrun", {31'd0, underrun}, 32'd0);
    endtask

    initial begin
        rst          = 1'b0;
        result_valid = 1'b0;
        result_data  = '0;
        read_en      = 1'b0;
        @(posedge clk);
        #1;

        // Capture and five back-to-back reads
        do_reset();
        step(1'b1, DATA_A, 1'b0);
        chk("word0_fixed", PRDATA, 32'h01234567);
        for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0);

        // Stalled reads with random gaps of 0-3 cycles
        step(1'b1, DATA_A, 1'b0);
        for (int i = 0; i < 5; i++) begin
            int gap;
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) step(1'b0, '0, 1'b0);
            step(1'b0, '0, 1'b1);
        end
        step(1'b0, '0, 1'b0);

        // Overrun: new result mid-unload is dropped
        step(1'b1, DATA_A, 1'b0);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1);
        step(1'b1, DATA_B, 1'b0);
        step(1'b0, '0, 1'b1);
        step(1'b1, DATA_B, 1'b1);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0);

        // Final read coinciding with a new result
        do_reset();
        step(1'b1, DATA_A, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1);
        step(1'b1, DATA_B, 1'b1);
        chk("b_word0", PRDATA, 32'hFEDCBA98);
        for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0);

        // Underrun, then normal operation
        do_reset();
        step(1'b0, '0, 1'b1);
        step(1'b1, DATA_B, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0);

        // Reset mid-unload
        do_reset();
        step(1'b1, DATA_A, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1);
        do_reset();
        step(1'b0, '0, 1'b0);
        step(1'b1, DATA_B, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
